dispmux8_ctl: RTL and testbench

Time-multiplexing controller for the 8-digit seven-segment display. It holds eight 7-bit digit codes and scans them one digit at a time. For the selected digit it drives that digit's code to the downstream `sevenseg_ext_n` decoder's `d` input and asserts the matching active-low anode enable. A prescaler sets the per-digit dwell time. A programmable blanking gap at the start of each dwell suppresses ghosting between digits.

---
 rtl/dispmux8_ctl.sv | 75 +++++++
 tb/tb_dispmux8_ctl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dispmux8_ctl.sv
// Eight-digit seven-segment scan controller: steps through d0..d7 with a
// fixed per-digit dwell, blanking all anodes at the start of each dwell.
module dispmux8_ctl #(
  parameter int CLKFREQ      = 100_000_000,
  parameter int RATE         = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] d0,
  input  logic [6:0] d1,
  input  logic [6:0] d2,
  input  logic [6:0] d3,
  input  logic [6:0] d4,
  input  logic [6:0] d5,
  input  logic [6:0] d6,
  input  logic [6:0] d7,
  input  logic [7:0] en_mask,
  output logic [6:0] dcode,
  output logic [7:0] an_n,
  output logic       frame_tick
);

  localparam int DIV   = CLKFREQ / RATE;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  if (DIV < 2 || BLANK_CYCLES >= DIV) begin : g_param_check
    $error("dispmux8_ctl: need CLKFREQ/RATE >= 2 and BLANK_CYCLES < CLKFREQ/RATE");
  end

  logic [CNT_W-1:0] cnt;
  logic [2:0]       sel;
  logic [6:0]       d_sel;
  logic             dwell_end;
  logic             blank;

  assign dwell_end = (cnt == CNT_MAX);
  // With BLANK_CYCLES = 0 the comparison is never true, so SHOW is permanent.
  assign blank     = (cnt < BLANK_END);

  always_comb begin
    d_sel = d0;
    case (sel)
      3'd1:    d_sel = d1;
      3'd2:    d_sel = d2;
      3'd3:    d_sel = d3;
      3'd4:    d_sel = d4;
      3'd5:    d_sel = d5;
      3'd6:    d_sel = d6;
      3'd7:    d_sel = d7;
      default: d_sel = d0;
    endcase
  end

  // Scan state and registered outputs; dcode tracks sel even while blanked so
  // the code has settled before the anode turns on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sel        <= 3'd0;
      dcode      <= 7'd0;
      an_n       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= dwell_end ? '0 : cnt + CNT_W'(1);
      sel        <= dwell_end ? sel + 3'd1 : sel;
      dcode      <= d_sel;
      an_n       <= (blank || !en_mask[sel]) ? 8'hFF : ~(8'b1 << sel);
      frame_tick <= (sel == 3'd7) && dwell_end;
    end
  end

endmodule

// File: tb/tb_dispmux8_ctl.sv
// Directed bench for dispmux8_ctl with DIV=10, BLANK_CYCLES=2.
module tb_dispmux8_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0] en_mask;
  logic [6:0] dcode;
  logic [7:0] an_n;
  logic       frame_tick;

  int checks = 0;
  int failures = 0;
  int k = 0;
  int pulses = 0;
  int pulse_at[$];

  typedef struct {
    logic [7:0] mask;
    logic [7:0] an;
    logic [6:0] code;
  } vec_t;
  vec_t vt[16];

  dispmux8_ctl #(.CLKFREQ(100), .RATE(10), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .en_mask(en_mask), .dcode(dcode), .an_n(an_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog k=%0d timeout", k);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge. k = edges since release.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
    if (frame_tick === 1'b1) begin
      pulses++;
      pulse_at.push_back(k);
    end
  endtask

  initial begin
    vt[0]  = '{8'hFF, 8'hFE, 7'd0};
    vt[1]  = '{8'hFF, 8'hFD, 7'd1};
    vt[2]  = '{8'hFF, 8'hFB, 7'd2};
    vt[3]  = '{8'hFF, 8'hF7, 7'd3};
    vt[4]  = '{8'hFF, 8'hEF, 7'd4};
    vt[5]  = '{8'hFF, 8'hDF, 7'd5};
    vt[6]  = '{8'hFF, 8'hBF, 7'd6};
    vt[7]  = '{8'hFF, 8'h7F, 7'd7};
    vt[8]  = '{8'hAA, 8'hFF, 7'd0};
    vt[9]  = '{8'hAA, 8'hFD, 7'd1};
    vt[10] = '{8'hAA, 8'hFF, 7'd2};
    vt[11] = '{8'hAA, 8'hF7, 7'd3};
    vt[12] = '{8'hAA, 8'hFF, 7'd4};
    vt[13] = '{8'hAA, 8'hDF, 7'd5};
    vt[14] = '{8'hAA, 8'hFF, 7'd6};
    vt[15] = '{8'hAA, 8'h7F, 7'd7};

    d0 = 7'd0; d1 = 7'd1; d2 = 7'd2; d3 = 7'd3;
    d4 = 7'd4; d5 = 7'd5; d6 = 7'd6; d7 = 7'd7;
    en_mask = 8'hFF;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_an_n", an_n, 8'hFF);
      chk("rst_dcode", dcode, 7'd0);
      chk("rst_frame_tick", frame_tick, 1'b0);
    end
    rst_n = 1'b1;
    k = 0;

    // Frame 1 full scan, frame 2 with alternate digits masked
    for (int r = 0; r < 16; r++) begin
      en_mask = vt[r].mask;
      for (int i = 0; i < 10; i++) begin
        step();
        chk("an_n", an_n, (i < 2) ? 8'hFF : vt[r].an);
        chk("dcode", dcode, vt[r].code);
        chk("frame_tick", frame_tick, (k % 80 == 0) ? 1'b1 : 1'b0);
      end
    end

    // Frame 3: d3 changes after the 4th SHOW output of digit 3
    en_mask = 8'hFF;
    for (int dg = 0; dg < 8; dg++) begin
      for (int i = 0; i < 10; i++) begin
        step();
        chk("live_an_n", an_n, (i < 2) ? 8'hFF : vt[dg].an);
        chk("live_dcode", dcode, (dg == 3 && i >= 6) ? 7'd64 : vt[dg].code);
        if (dg == 3 && i == 5) d3 = 7'd64;
      end
    end

    chk("pulse_count", pulses, 3);
    if (pulse_at.size() >= 3) begin
      chk("pulse0_pos", pulse_at[0], 80);
      chk("pulse1_pos", pulse_at[1], 160);
      chk("pulse2_pos", pulse_at[2], 240);
    end else begin
      chk("pulse_list_size", pulse_at.size(), 3);
    end

    // Async reset while digit 5 is lit
    for (int i = 0; i < 55; i++) step();
    chk("pre_rst_an_n", an_n, 8'hDF);
    chk("pre_rst_dcode", dcode, 7'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an_n", an_n, 8'hFF);
    chk("async_dcode", dcode, 7'd0);
    chk("async_frame_tick", frame_tick, 1'b0);
    @(negedge clk);
    chk("hold_an_n", an_n, 8'hFF);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      chk("restart_an_n", an_n, (i < 2 || i == 10) ? 8'hFF : 8'hFE);
      chk("restart_dcode", dcode, (i == 10) ? 7'd1 : 7'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
